// File: rtl/voice_allocator_pkg.sv
// MIDI message types and voice-allocator shared types.
// Package VOICE holds allocator states, voice entries and candidate classes.
package MIDI;
    typedef enum logic [3:0] {
        NOTE_OFF         = 4'h8,
        NOTE_ON          = 4'h9,
        POLY_PRESSURE    = 4'hA,
        CONTROL_CHANGE   = 4'hB,
        PROGRAM_CHANGE   = 4'hC,
        CHANNEL_PRESSURE = 4'hD,
        PITCH_BEND       = 4'hE,
        SYSTEM           = 4'hF
    } message_type_t;

    typedef struct packed {
        message_type_t message_type;
        logic [6:0]    data_byte1;
        logic [6:0]    data_byte2;
    } message_t;
endpackage

package VOICE;
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} alloc_state_t;

    localparam int unsigned STAMP_W_MAX = 16;

    typedef struct packed {
        logic [6:0]             note;
        logic [6:0]             velocity;
        logic                   gate;
        logic                   sustained;
        logic [STAMP_W_MAX-1:0] stamp;
    } voice_entry_t;

    // Declaration order is priority order: lower value wins.
    typedef enum logic [2:0] {
        CAND_SAME, CAND_FREE, CAND_RELEASING, CAND_GATED, CAND_NONE
    } cand_class_t;

    typedef enum logic [2:0] {
        OP_NONE, OP_ON, OP_OFF, OP_PEDAL_DOWN, OP_PEDAL_UP
    } op_kind_t;

    localparam logic [6:0] SUSTAIN_CC = 7'd64;

    function automatic op_kind_t decode_op(input MIDI::message_t m, input bit sustain_en);
        decode_op = OP_NONE;
        case (m.message_type)
            MIDI::NOTE_ON:  decode_op = (m.data_byte2 == 7'd0) ? OP_OFF : OP_ON;
            MIDI::NOTE_OFF: decode_op = OP_OFF;
            MIDI::CONTROL_CHANGE:
                if (sustain_en && m.data_byte1 == SUSTAIN_CC)
                    decode_op = (m.data_byte2 >= 7'd64) ? OP_PEDAL_DOWN : OP_PEDAL_UP;
            default: decode_op = OP_NONE;
        endcase
    endfunction
endpackage

// File: rtl/voice_allocator_candidate.sv
// Best-so-far versus current-voice comparison for the allocation scan.
module voice_candidate_compare
    import VOICE::*;
#(
    parameter int unsigned IDX_W = 3
) (
    input  cand_class_t                i_best_class,
    input  logic [IDX_W-1:0]           i_best_idx,
    input  logic [STAMP_W_MAX-1:0]     i_best_age,
    input  cand_class_t                i_cur_class,
    input  logic [IDX_W-1:0]           i_cur_idx,
    input  logic [STAMP_W_MAX-1:0]     i_cur_age,
    output cand_class_t                o_win_class,
    output logic [IDX_W-1:0]           o_win_idx,
    output logic [STAMP_W_MAX-1:0]     o_win_age
);
    logic w_cur_wins;

    always_comb begin
        w_cur_wins = 1'b0;
        if (i_cur_class < i_best_class)
            w_cur_wins = 1'b1;
        // Ascending scan: ties keep the earlier (lower-index) voice.
        else if (i_cur_class == i_best_class &&
                 (i_cur_class == CAND_RELEASING || i_cur_class == CAND_GATED) &&
                 i_cur_age > i_best_age)
            w_cur_wins = 1'b1;

        o_win_class = w_cur_wins ? i_cur_class : i_best_class;
        o_win_idx   = w_cur_wins ? i_cur_idx   : i_best_idx;
        o_win_age   = w_cur_wins ? i_cur_age   : i_best_age;
    end
endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: sequential one-voice-per-clock scan, then commit.
// Optional sustain pedal (CC64) when SUSTAIN_PEDAL_EN is defined.
module voice_allocator
    import VOICE::*;
#(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned STAMP_W    = 8
) (
    input  logic                    clock_50_000_000,
    input  logic                    reset_l,
    input  MIDI::message_t          message,
    input  logic                    message_ready,
    input  logic [NUM_VOICES-1:0]   voice_idle,
    output logic [NUM_VOICES*7-1:0] voice_note,
    output logic [NUM_VOICES*7-1:0] voice_velocity,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [NUM_VOICES-1:0]   voice_trigger,
    output logic                    busy,
    output logic [7:0]              drop_count
);
    localparam int unsigned IDX_W = $clog2(NUM_VOICES);
    localparam logic [STAMP_W_MAX-1:0] STAMP_MASK = STAMP_W_MAX'((1 << STAMP_W) - 1);
`ifdef SUSTAIN_PEDAL_EN
    localparam bit SUSTAIN_EN = 1'b1;
`else
    localparam bit SUSTAIN_EN = 1'b0;
`endif

    alloc_state_t r_state, w_state_next;
    voice_entry_t r_voice [NUM_VOICES];

    logic                   r_pend_valid;
    op_kind_t               r_pend_op, r_cur_op;
    logic [6:0]             r_pend_note, r_pend_vel, r_cur_note, r_cur_vel;
    logic [IDX_W-1:0]       r_scan_idx, r_best_idx;
    cand_class_t            r_best_class;
    logic [STAMP_W_MAX-1:0] r_best_age, r_stamp_now;
    logic [NUM_VOICES-1:0]  r_off_mask, r_trigger;
    logic                   r_pedal_down;
    logic [7:0]             r_drop_count;

    op_kind_t               w_in_op, w_src_op, w_start_op;
    logic                   w_in_valid, w_src_valid;
    logic [6:0]             w_src_note, w_src_vel, w_start_note, w_start_vel;
    logic                   w_launch_idle, w_pedal_idle, w_launch_commit, w_start;
    voice_entry_t           w_cur_voice;
    cand_class_t            w_cur_class, w_win_class;
    logic [STAMP_W_MAX-1:0] w_cur_age, w_win_age;
    logic [IDX_W-1:0]       w_win_idx;

    assign w_in_op     = message_ready ? decode_op(message, SUSTAIN_EN) : OP_NONE;
    assign w_in_valid  = (w_in_op != OP_NONE);
    // A held slot entry always goes ahead of a message arriving the same cycle.
    assign w_src_valid = r_pend_valid || w_in_valid;
    assign w_src_op    = r_pend_valid ? r_pend_op   : w_in_op;
    assign w_src_note  = r_pend_valid ? r_pend_note : message.data_byte1;
    assign w_src_vel   = r_pend_valid ? r_pend_vel  : message.data_byte2;

    assign w_launch_idle   = (r_state == IDLE) && w_src_valid &&
                             (w_src_op == OP_ON || w_src_op == OP_OFF);
    assign w_pedal_idle    = (r_state == IDLE) && w_src_valid &&
                             (w_src_op == OP_PEDAL_DOWN || w_src_op == OP_PEDAL_UP);
    assign w_launch_commit = (r_state == COMMIT) && r_pend_valid &&
                             (r_pend_op == OP_ON || r_pend_op == OP_OFF);
    assign w_start         = w_launch_idle || w_launch_commit;
    assign w_start_op      = w_launch_commit ? r_pend_op   : w_src_op;
    assign w_start_note    = w_launch_commit ? r_pend_note : w_src_note;
    assign w_start_vel     = w_launch_commit ? r_pend_vel  : w_src_vel;

    always_comb begin
        w_cur_voice = r_voice[r_scan_idx];
        w_cur_age   = (r_stamp_now - w_cur_voice.stamp) & STAMP_MASK;
        if ((w_cur_voice.gate || !voice_idle[r_scan_idx]) && w_cur_voice.note == r_cur_note)
            w_cur_class = CAND_SAME;
        else if (!w_cur_voice.gate && voice_idle[r_scan_idx])
            w_cur_class = CAND_FREE;
        else if (!w_cur_voice.gate)
            w_cur_class = CAND_RELEASING;
        else
            w_cur_class = CAND_GATED;
    end

    voice_candidate_compare #(.IDX_W(IDX_W)) u_compare (
        .i_best_class (r_best_class),
        .i_best_idx   (r_best_idx),
        .i_best_age   (r_best_age),
        .i_cur_class  (w_cur_class),
        .i_cur_idx    (r_scan_idx),
        .i_cur_age    (w_cur_age),
        .o_win_class  (w_win_class),
        .o_win_idx    (w_win_idx),
        .o_win_age    (w_win_age)
    );

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_launch_idle) w_state_next = SCAN;
            SCAN:    if (r_scan_idx == IDX_W'(NUM_VOICES - 1)) w_state_next = COMMIT;
            COMMIT:  w_state_next = w_launch_commit ? SCAN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) r_voice[i] <= '0;
            r_pend_valid <= 1'b0;
            r_pend_op    <= OP_NONE;
            r_pend_note  <= '0;
            r_pend_vel   <= '0;
            r_cur_op     <= OP_NONE;
            r_cur_note   <= '0;
            r_cur_vel    <= '0;
            r_scan_idx   <= '0;
            r_best_idx   <= '0;
            r_best_class <= CAND_NONE;
            r_best_age   <= '0;
            r_off_mask   <= '0;
            r_stamp_now  <= '0;
            r_pedal_down <= 1'b0;
            r_trigger    <= '0;
            r_drop_count <= '0;
        end else begin
            r_trigger <= '0;

            if (r_state == IDLE) begin
                if (r_pend_valid) begin
                    r_pend_valid <= w_in_valid;
                    r_pend_op    <= w_in_op;
                    r_pend_note  <= message.data_byte1;
                    r_pend_vel   <= message.data_byte2;
                end
            end else if (w_in_valid) begin
                if (r_pend_valid) begin
                    if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
                end else begin
                    r_pend_valid <= 1'b1;
                    r_pend_op    <= w_in_op;
                    r_pend_note  <= message.data_byte1;
                    r_pend_vel   <= message.data_byte2;
                end
            end
            if (w_launch_commit) r_pend_valid <= 1'b0;

            if (w_start) begin
                r_cur_op     <= w_start_op;
                r_cur_note   <= w_start_note;
                r_cur_vel    <= w_start_vel;
                r_scan_idx   <= '0;
                r_best_idx   <= '0;
                r_best_class <= CAND_NONE;
                r_best_age   <= '0;
            end else if (r_state == SCAN) begin
                r_best_idx   <= w_win_idx;
                r_best_class <= w_win_class;
                r_best_age   <= w_win_age;
                r_off_mask[r_scan_idx] <= w_cur_voice.gate && (w_cur_voice.note == r_cur_note);
                r_scan_idx   <= r_scan_idx + 1'b1;
            end

            if (r_state == COMMIT) begin
                if (r_cur_op == OP_ON) begin
                    r_voice[r_best_idx].note      <= r_cur_note;
                    r_voice[r_best_idx].velocity  <= r_cur_vel;
                    r_voice[r_best_idx].gate      <= 1'b1;
                    r_voice[r_best_idx].sustained <= 1'b0;
                    r_voice[r_best_idx].stamp     <= r_stamp_now;
                    r_trigger[r_best_idx]         <= 1'b1;
                    r_stamp_now <= (r_stamp_now + 1'b1) & STAMP_MASK;
                end else begin
                    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                        if (r_off_mask[i]) begin
                            if (r_pedal_down) r_voice[i].sustained <= 1'b1;
                            else              r_voice[i].gate      <= 1'b0;
                        end
                    end
                end
            end

            if (w_pedal_idle) begin
                if (w_src_op == OP_PEDAL_DOWN) begin
                    r_pedal_down <= 1'b1;
                end else begin
                    r_pedal_down <= 1'b0;
                    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                        if (r_voice[i].sustained) begin
                            r_voice[i].gate      <= 1'b0;
                            r_voice[i].sustained <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        voice_note     = '0;
        voice_velocity = '0;
        voice_gate     = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            voice_note[7*i +: 7]     = r_voice[i].note;
            voice_velocity[7*i +: 7] = r_voice[i].velocity;
            voice_gate[i]            = r_voice[i].gate;
        end
    end

    assign voice_trigger = r_trigger;
    assign busy          = (r_state != IDLE);
    assign drop_count    = r_drop_count;
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Polyphonic voice scheduler that turns MIDI NOTE_ON/NOTE_OFF messages into per-voice note, velocity and gate assignments for the oscillator/envelope voice bank. It sits beside the parameter controller on the same MIDI message stream and shares NUM_VOICES hardware voices between incoming notes. Free voices are preferred. When none are free, the oldest releasing voice is stolen first, then the oldest gated voice. Selection is a sequential scan, one voice per clock.

Parameters:
NUM_VOICES, 8, number of hardware voices (power of two, 2..16).
STAMP_W, 8, width of the allocation-age stamp.

Ports:
clock_50_000_000  input  1  system clock.
reset_l  input  1  reset, asynchronous, active-low.
message  input  MIDI::message_t  decoded MIDI message (message_type, data_byte1 = note, data_byte2 = velocity).
message_ready  input  1  message valid, single-cycle pulse.
voice_idle  input  NUM_VOICES  per-voice envelope finished release; 1 = voice silent.
voice_note  output  NUM_VOICES*7  assigned note per voice, voice i at [7i+6:7i].
voice_velocity  output  NUM_VOICES*7  assigned velocity per voice, same packing.
voice_gate  output  NUM_VOICES  key held per voice.
voice_trigger  output  NUM_VOICES  one-cycle pulse restarting voice i's envelope.
busy  output  1  allocator scanning.
drop_count  output  8  saturating count of dropped messages.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pending slot empty; stamp counter 0; per-voice stamps 0.
- Accepted messages: NOTE_ON, NOTE_OFF. A NOTE_ON with velocity 0 is treated as NOTE_OFF. All other types are ignored and never occupy the pending slot.
- Pending slot: one entry.
  - message_ready in IDLE with the slot empty: the message goes straight to the SCAN setup.
  - message_ready while busy: the message is stored in the slot.
  - Slot already full: the new message is dropped and drop_count increments, saturating at 255.
- FSM: IDLE -> SCAN -> COMMIT -> IDLE.
  - In COMMIT, if the pending slot is full, the FSM moves to SCAN with that entry and the slot is cleared the same cycle.
- SCAN visits voice 0..NUM_VOICES-1, one per cycle. busy = 1 in SCAN and COMMIT.
- Latency: message_ready to voice_trigger/gate update is NUM_VOICES+2 cycles (10 at default).
- NOTE_ON candidate priority, highest first:
  (a) a voice already holding the same note (gated or not idle): retrigger that voice;
  (b) the lowest-index voice with gate = 0 and voice_idle = 1;
  (c) the oldest voice with gate = 0 and voice_idle = 0 (releasing);
  (d) the oldest gated voice (steal).
- Age ordering:
  - Age = (stamp_now - voice_stamp) mod 2^STAMP_W; larger is older.
  - On equal age, the lower index wins.
  - Wrap-around is tolerated by the modular subtraction.
- NOTE_ON COMMIT on the chosen voice:
  - note and velocity written;
  - gate = 1;
  - voice_trigger pulses for exactly one cycle;
  - voice stamp = stamp_now;
  - stamp_now increments, wrapping.
- NOTE_OFF: SCAN clears gate on every gated voice whose note matches; no trigger. Note and velocity are retained for the release phase. An unmatched NOTE_OFF changes nothing and still takes the full latency.
- A voice_idle change during SCAN affects only voices not yet visited.
- Reset mid-scan: immediate return to reset values; the pending message is lost.

Optional Feature:
SUSTAIN_PEDAL_EN.
- Defined:
  - CONTROL_CHANGE controller 64 with value >= 64 sets pedal_down.
  - While pedal_down, a matching NOTE_OFF marks the voice sustained instead of clearing its gate.
  - Pedal release (value < 64) clears gate on all sustained voices in one cycle, taken only in IDLE. A pedal message arriving while busy is queued in the pending slot like a note message.
  - A NOTE_ON retriggering a sustained voice clears its sustained flag.
- Undefined: CC64 is ignored; there is no sustained state.

Decomposition:
- Package VOICE holds:
  - alloc_state_t enum {IDLE, SCAN, COMMIT};
  - voice_entry_t struct {note[6:0], velocity[6:0], gate, sustained, stamp};
  - candidate class enum {CAND_SAME, CAND_FREE, CAND_RELEASING, CAND_GATED, CAND_NONE};
  - SUSTAIN_CC = 64.
- One sub-module, voice_candidate_compare: combinational best-so-far vs current-voice comparison returning the winner index and class. It is instantiated once, with the scan registers held in voice_allocator.

Test Plan:
- Reset, then NOTE_ON note 60 vel 100 -> after 10 cycles voice 0: note 60, vel 100, gate 1, voice_trigger[0] pulse 1 cycle; busy high cycles 1..9.
- Eight NOTE_ONs 60..67 with all voice_idle = 1, then NOTE_ON 70 -> voices 0..7 filled in order; note 70 steals voice 0 (oldest gated), trigger[0].
- NOTE_OFF 62 with voice 2 voice_idle = 0, then NOTE_ON 72 when all other voices are gated -> voice 2 chosen (releasing beats gated).
- NOTE_ON 64 twice -> second NOTE_ON retriggers the same voice; no other voice changes.
- NOTE_ON velocity 0 for note 61 -> gate cleared on its voice; three messages back-to-back while busy -> second pending, third dropped, drop_count = 1.
- SUSTAIN_PEDAL_EN: CC64=127, NOTE_OFF 60 -> gate stays 1; CC64=0 -> gate 0 within 1 cycle of IDLE.
